// File: rtl/rv_trace_pkg.sv
// -----------------------------------------------------------------------------
// rv_trace_pkg
// Shared types for the RISC-V commit trace monitor:
//   trc_state_t   - monitor life-cycle states (IDLE, RUN, PASS, HANG)
//   trace_entry_t - one committed instruction {pc, wb}, sized for the widest
//                   supported core (XLEN_MAX); narrower cores zero-extend.
// -----------------------------------------------------------------------------
package rv_trace_pkg;

    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_HANG = 2'd3
    } trc_state_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] wb;
    } trace_entry_t;

endpackage

// File: rtl/rv_trace_fifo.sv
// -----------------------------------------------------------------------------
// rv_trace_fifo
// First-word-fall-through FIFO holding trace entries. The head entry is always
// presented on rdata while the FIFO is not empty. A push while full is only
// accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push, wdata     - write request and data
//   pop             - remove head entry (ignored when empty)
//   rdata           - head entry
//   full, empty     - occupancy flags
//   count           - number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module rv_trace_fifo
    import rv_trace_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rv_trace_monitor.sv
// -----------------------------------------------------------------------------
// rv_trace_monitor
// Watches a core's next-PC and write-back buses, detects instruction commits
// (NPC changed since last cycle), buffers {pc, wb} trace entries in a FIFO,
// counts commits and drops, and reports test end by PASS_PC commit or hang.
// Ports:
//   clk, RN                 - clock, asynchronous active-low reset
//   npc_i, wb_i             - observed core NPC and write-back value
//   trc_ready_i/trc_valid_o - trace stream handshake, head on trc_pc_o/trc_wb_o
//   retired_o               - commit count (wraps)
//   drop_o, overflow_o      - saturating drop count, sticky overflow flag
//   done_o, pass_o, hang_o  - test status
//   sig_o                   - running write-back signature
// Optional feature: define RV_TRACE_SIG_EN to build the signature register;
// otherwise sig_o is tied to zero.
// -----------------------------------------------------------------------------
module rv_trace_monitor
    import rv_trace_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 16,
    parameter int unsigned     HANG_CYCLES = 64,
    parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            RN,
    input  logic [XLEN-1:0] npc_i,
    input  logic [XLEN-1:0] wb_i,
    input  logic            trc_ready_i,
    output logic            trc_valid_o,
    output logic [XLEN-1:0] trc_pc_o,
    output logic [XLEN-1:0] trc_wb_o,
    output logic [31:0]     retired_o,
    output logic [15:0]     drop_o,
    output logic            overflow_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            hang_o,
    output logic [XLEN-1:0] sig_o
);

    localparam int unsigned SW = $clog2(HANG_CYCLES);

    trc_state_t         state_r;
    trc_state_t         state_n_s;
    logic [XLEN-1:0]    prev_pc_r;
    logic [SW-1:0]      stall_r;
    logic [31:0]        retired_r;
    logic [15:0]        drop_r;
    logic               overflow_r;
    logic               done_r;
    logic               pass_r;
    logic               hang_r;

    logic               commit_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic [2*XLEN-1:0]  fifo_rdata_s;
    trace_entry_t       head_s;

    // Commits are only recognised while running; the IDLE cycle primes prev_pc.
    assign commit_s = (state_r == ST_RUN) && (npc_i != prev_pc_r);
    assign pop_s    = trc_ready_i && !fifo_empty_s;
    assign push_s   = commit_s && (!fifo_full_s || pop_s);
    assign drop_s   = commit_s && fifo_full_s && !pop_s;

    rv_trace_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RN),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({npc_i, wb_i}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Unpack the head entry into the shared trace-entry layout.
    always_comb begin
        head_s.pc = XLEN_MAX'(fifo_rdata_s[2*XLEN-1:XLEN]);
        head_s.wb = XLEN_MAX'(fifo_rdata_s[XLEN-1:0]);
    end

    assign trc_valid_o = (fifo_count_s != {($clog2(DEPTH)+1){1'b0}});
    assign trc_pc_o    = XLEN'(head_s.pc);
    assign trc_wb_o    = XLEN'(head_s.wb);
    assign retired_o   = retired_r;
    assign drop_o      = drop_r;
    assign overflow_o  = overflow_r;
    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign hang_o      = hang_r;

    // Next-state logic: PASS and HANG are terminal until reset.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: state_n_s = ST_RUN;
            ST_RUN: begin
                if (commit_s) begin
                    if (npc_i == PASS_PC) begin
                        state_n_s = ST_PASS;
                    end else begin
                        state_n_s = ST_RUN;
                    end
                end else if (stall_r == SW'(HANG_CYCLES - 1)) begin
                    state_n_s = ST_HANG;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_PASS: state_n_s = ST_PASS;
            ST_HANG: state_n_s = ST_HANG;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags derived from the next state.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_r <= ST_IDLE;
            pass_r  <= 1'b0;
            hang_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pass_r  <= (state_n_s == ST_PASS);
            hang_r  <= (state_n_s == ST_HANG);
            done_r  <= (state_n_s == ST_PASS) || (state_n_s == ST_HANG);
        end
    end

    // Previous-PC capture, every cycle regardless of state.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            prev_pc_r <= {XLEN{1'b0}};
        end else begin
            prev_pc_r <= npc_i;
        end
    end

    // Commit, drop and stall bookkeeping; nothing moves outside RUN.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            retired_r  <= 32'd0;
            drop_r     <= 16'd0;
            overflow_r <= 1'b0;
            stall_r    <= {SW{1'b0}};
        end else begin
            if (commit_s) begin
                retired_r <= retired_r + 32'd1;
                stall_r   <= {SW{1'b0}};
            end else if (state_r == ST_RUN) begin
                stall_r <= stall_r + SW'(1'b1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'd1;
                end
            end
        end
    end

`ifdef RV_TRACE_SIG_EN
    logic [XLEN-1:0] sig_r;

    // Rotate-left-by-one then fold in the committed write-back value.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            sig_r <= {XLEN{1'b0}};
        end else if (commit_s) begin
            sig_r <= {sig_r[XLEN-2:0], sig_r[XLEN-1]} ^ wb_i;
        end
    end

    assign sig_o = sig_r;
`else
    assign sig_o = {XLEN{1'b0}};
`endif

endmodule
